// File: rtl/rank_pkg.sv
// Shared definitions for the rank_argmax min/max selector.
//   DEF_DATA_W / DEF_IDX_W : default score and index widths
//   state_e                : scan FSM encoding
//   score_t                : unsigned PageRank score
package rank_pkg;

  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_IDX_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef logic [DEF_DATA_W-1:0] score_t;

endpackage

// File: rtl/mag_cmp_u16.sv
// Combinational unsigned magnitude comparator for 16-bit scores.
//   a, b : operands (unsigned)
//   lt   : a < b
//   gt   : a > b
//   eq   : a == b
module mag_cmp_u16
  import rank_pkg::*;
(
  input  score_t a,
  input  score_t b,
  output logic   lt,
  output logic   gt,
  output logic   eq
);

  always_comb begin
    lt = (a < b);
    gt = (a > b);
    eq = (a == b);
  end

endmodule

// File: rtl/rank_argmax.sv
// Streaming unsigned min/max selector for PageRank score vectors.
// After start, accepts len scores over a valid/ready stream and tracks the running
// max/min with the index of their first occurrence; pulses done once all are seen.
//   clk, rst_n       : clock, asynchronous active-low reset
//   start, len       : begin a scan of len scores (sampled in IDLE only)
//   in_valid/in_data : score stream; in_ready high only while scanning
//   busy, done       : scan in progress / one-cycle completion pulse
//   empty            : last scan had len = 0
//   max_val/max_idx  : largest score and its first index; max_tie if repeated
//   min_val/min_idx  : smallest score and its first index
module rank_argmax
  import rank_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned IDX_W  = DEF_IDX_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [IDX_W-1:0]  len,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              busy,
  output logic              done,
  output logic              empty,
  output logic [DATA_W-1:0] max_val,
  output logic [IDX_W-1:0]  max_idx,
  output logic [DATA_W-1:0] min_val,
  output logic [IDX_W-1:0]  min_idx,
  output logic              max_tie
);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  len_q, len_d;
  logic [DATA_W-1:0] max_val_q, max_val_d;
  logic [DATA_W-1:0] min_val_q, min_val_d;
  logic [IDX_W-1:0]  max_idx_q, max_idx_d;
  logic [IDX_W-1:0]  min_idx_q, min_idx_d;
  logic              max_tie_q, max_tie_d;
  logic              empty_q, empty_d;

  logic accept;
  logic max_lt, max_gt, max_eq;
  logic min_lt, min_gt, min_eq;

  // in_data compared against each held bound
  mag_cmp_u16 u_cmp_max (
    .a  (in_data),
    .b  (max_val_q),
    .lt (max_lt),
    .gt (max_gt),
    .eq (max_eq)
  );

  mag_cmp_u16 u_cmp_min (
    .a  (in_data),
    .b  (min_val_q),
    .lt (min_lt),
    .gt (min_gt),
    .eq (min_eq)
  );

  assign accept = in_valid && (state_q == ST_RUN);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    max_val_d = max_val_q;
    min_val_d = min_val_q;
    max_idx_d = max_idx_q;
    min_idx_d = min_idx_q;
    max_tie_d = max_tie_q;
    empty_d   = empty_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (len != '0) begin
            len_d   = len;
            cnt_d   = '0;
            empty_d = 1'b0;
            state_d = ST_RUN;
          end else begin
            empty_d   = 1'b1;
            max_val_d = '0;
            min_val_d = '0;
            max_idx_d = '0;
            min_idx_d = '0;
            max_tie_d = 1'b0;
            state_d   = ST_DONE;
          end
        end
      end
      ST_RUN: begin
        if (accept) begin
          if (cnt_q == '0) begin
            max_val_d = in_data;
            min_val_d = in_data;
            max_idx_d = cnt_q;
            min_idx_d = cnt_q;
            max_tie_d = 1'b0;
          end else begin
            if (max_gt) begin
              max_val_d = in_data;
              max_idx_d = cnt_q;
              max_tie_d = 1'b0;
            end else if (max_eq) begin
              max_tie_d = 1'b1;
            end
            // Equal-to-min keeps the first index, so only strict less replaces.
            if (min_lt) begin
              min_val_d = in_data;
              min_idx_d = cnt_q;
            end
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == len_q - 1'b1) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      len_q     <= '0;
      max_val_q <= '0;
      min_val_q <= '0;
      max_idx_q <= '0;
      min_idx_q <= '0;
      max_tie_q <= 1'b0;
      empty_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      max_val_q <= max_val_d;
      min_val_q <= min_val_d;
      max_idx_q <= max_idx_d;
      min_idx_q <= min_idx_d;
      max_tie_q <= max_tie_d;
      empty_q   <= empty_d;
    end
  end

  always_comb begin
    in_ready = (state_q == ST_RUN);
    busy     = (state_q != ST_IDLE);
    done     = (state_q == ST_DONE);
    empty    = empty_q;
    max_val  = max_val_q;
    max_idx  = max_idx_q;
    min_val  = min_val_q;
    min_idx  = min_idx_q;
    max_tie  = max_tie_q;
  end

  // Comparator outputs not needed by the selection rules.
  logic unused_cmp;
  assign unused_cmp = max_lt ^ min_gt ^ min_eq;

endmodule

// File: tb/tb_rank_argmax.sv
// Self-checking bench for rank_argmax: directed scans plus randomized data,
// checked against a simple array-based reference of max/min/first-index/tie.
module tb_rank_argmax;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  len;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        busy;
  logic        done;
  logic        empty;
  logic [15:0] max_val;
  logic [7:0]  max_idx;
  logic [15:0] min_val;
  logic [7:0]  min_idx;
  logic        max_tie;

  rank_argmax dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .len      (len),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .busy     (busy),
    .done     (done),
    .empty    (empty),
    .max_val  (max_val),
    .max_idx  (max_idx),
    .min_val  (min_val),
    .min_idx  (min_idx),
    .max_tie  (max_tie)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  logic [15:0] scan_data [256];
  int          exp_max, exp_min, exp_maxi, exp_mini, exp_tie;
  int          last_done_cyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: max/min by value, then first index by search, tie by counting.
  task automatic model(input int n);
    int cnt_max;
    exp_max = 0;
    exp_min = 0;
    exp_maxi = 0;
    exp_mini = 0;
    exp_tie = 0;
    if (n == 0) return;
    exp_max = int'(scan_data[0]);
    exp_min = int'(scan_data[0]);
    for (int j = 1; j < n; j++) begin
      if (int'(scan_data[j]) > exp_max) exp_max = int'(scan_data[j]);
      if (int'(scan_data[j]) < exp_min) exp_min = int'(scan_data[j]);
    end
    for (int j = n - 1; j >= 0; j--) begin
      if (int'(scan_data[j]) == exp_max) exp_maxi = j;
      if (int'(scan_data[j]) == exp_min) exp_mini = j;
    end
    cnt_max = 0;
    for (int j = 0; j < n; j++) if (int'(scan_data[j]) == exp_max) cnt_max++;
    exp_tie = (cnt_max > 1) ? 1 : 0;
  endtask

  task automatic check_results(input string tag);
    check({tag, "_max_val"}, 32'(max_val), 32'(exp_max));
    check({tag, "_max_idx"}, 32'(max_idx), 32'(exp_maxi));
    check({tag, "_min_val"}, 32'(min_val), 32'(exp_min));
    check({tag, "_min_idx"}, 32'(min_idx), 32'(exp_mini));
    check({tag, "_max_tie"}, 32'(max_tie), 32'(exp_tie));
  endtask

  // Run one scan of n beats from scan_data, with random stalls up to gapmax.
  // If inject is set, a start with a different len is raised alongside beat 1.
  task automatic run_scan(input string tag, input int n, input int gapmax, input bit inject);
    int i;
    int cyc;
    int gap;
    start = 1'b1;
    len   = 8'(n);
    step();
    start = 1'b0;
    cyc   = 1;
    model(n);
    if (n == 0) begin
      check({tag, "_done"}, 32'(done), 32'd1);
      check({tag, "_empty"}, 32'(empty), 32'd1);
      check({tag, "_ready"}, 32'(in_ready), 32'd0);
      check_results(tag);
      step();
      check({tag, "_done_drop"}, 32'(done), 32'd0);
      check({tag, "_ready_idle"}, 32'(in_ready), 32'd0);
      return;
    end
    check({tag, "_ready_k1"}, 32'(in_ready), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_empty_clr"}, 32'(empty), 32'd0);
    i = 0;
    while (i < n) begin
      gap = (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0;
      for (int g = 0; g < gap; g++) begin
        in_valid = 1'b0;
        in_data  = 16'($urandom);
        step();
        cyc++;
        check({tag, "_stall_done"}, 32'(done), 32'd0);
      end
      check({tag, "_ready"}, 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_data  = scan_data[i];
      if (inject && i == 1) begin
        start = 1'b1;
        len   = 8'(n + 4);
      end
      step();
      cyc++;
      in_valid = 1'b0;
      in_data  = 16'($urandom);
      start    = 1'b0;
      i++;
      check({tag, "_done_pulse"}, 32'(done), (i == n) ? 32'd1 : 32'd0);
      if (i == n) check({tag, "_ready_off"}, 32'(in_ready), 32'd0);
    end
    last_done_cyc = cyc;
    if (gapmax == 0) check({tag, "_latency"}, 32'(cyc), 32'(n + 1));
    check_results(tag);
    step();
    check({tag, "_done_once"}, 32'(done), 32'd0);
    check({tag, "_busy_idle"}, 32'(busy), 32'd0);
    check({tag, "_ready_idle"}, 32'(in_ready), 32'd0);
    check_results({tag, "_hold"});
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    len      = 8'd0;
    in_valid = 1'b0;
    in_data  = 16'd0;
    last_done_cyc = 0;
    repeat (2) step();
    #2 rst_n = 1'b1;
    step();

    // Reset state: every output low.
    check("rst_ready", 32'(in_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_empty", 32'(empty), 32'd0);
    check("rst_vals", {max_val, min_val}, 32'd0);
    check("rst_idx", {16'd0, max_idx, min_idx}, 32'd0);
    check("rst_tie", 32'(max_tie), 32'd0);

    // Abort a len=8 scan after 3 beats.
    start = 1'b1;
    len   = 8'd8;
    step();
    start = 1'b0;
    for (int j = 0; j < 3; j++) begin
      in_valid = 1'b1;
      in_data  = 16'(100 + j);
      step();
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("abort_ready", 32'(in_ready), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_vals", {max_val, min_val}, 32'd0);
    step();
    #2 rst_n = 1'b1;
    for (int j = 0; j < 8; j++) begin
      step();
      check("abort_no_done", 32'(done), 32'd0);
    end

    scan_data[0] = 16'd5;
    scan_data[1] = 16'd9;
    scan_data[2] = 16'd2;
    scan_data[3] = 16'd7;
    run_scan("post_rst", 4, 0, 1'b0);

    // Repeated max and stalls.
    scan_data[0] = 16'h0010;
    scan_data[1] = 16'hFFFF;
    scan_data[2] = 16'h0010;
    scan_data[3] = 16'hFFFF;
    scan_data[4] = 16'h0001;
    run_scan("tie_gaps", 5, 3, 1'b0);

    // Single beat, then unsigned ordering across the sign bit.
    scan_data[0] = 16'h8000;
    run_scan("len1", 1, 0, 1'b0);
    scan_data[0] = 16'h7FFF;
    scan_data[1] = 16'h8000;
    run_scan("unsigned", 2, 0, 1'b0);

    // Empty scan clears previous results.
    run_scan("len0", 0, 0, 1'b0);

    // Ignored start during RUN.
    scan_data[0] = 16'd40;
    scan_data[1] = 16'd10;
    scan_data[2] = 16'd40;
    run_scan("inject", 3, 0, 1'b1);
    step();
    check("inject_not_queued", 32'(busy), 32'd0);

    // Random scans with narrow value range so ties are common.
    for (int r = 0; r < 4; r++) begin
      int n;
      n = int'($urandom_range(2, 40));
      for (int j = 0; j < n; j++) scan_data[j] = 16'($urandom_range(0, 15) * 16'h1111);
      run_scan("random", n, r, 1'b0);
    end

    // Full-length descending ramp at full rate.
    for (int j = 0; j < 255; j++) scan_data[j] = 16'(254 - j);
    run_scan("ramp", 255, 0, 1'b0);
    check("ramp_done_cyc", 32'(last_done_cyc), 32'd256);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
